div3_serial_sched: RTL and testbench
====================================

Name: div3_serial_sched

Overview:
- Round-robin scheduler that shares one serial mod-3 residue engine among NREQ requesters.
- Each requester presents a DW-bit word. The block grants one requester, captures its word, and shifts it MSB-first through the residue engine, one bit per clock.
- It then returns the divisible-by-3 flag, the remainder and the requester ID on a valid/ready result port.
- Sits between parallel producers and the serial divisibility datapath.

Parameters:
- NREQ, 4, number of requesters (2..16).
- DW, 8, data word width in bits (≥2).
- IDW, derived localparam = max(1, clog2(NREQ)), requester ID width.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester word valid.
- req_data  in  NREQ*DW  packed words; requester i occupies bits [i*DW +: DW].
- req_ready  out  NREQ  one-hot grant/accept; transfer when req_valid[i] & req_ready[i].
- res_valid  out  1  result valid.
- res_ready  in  1  result consumer ready.
- res_div3  out  1  1 when the word is divisible by 3.
- res_rem  out  2  remainder (0, 1 or 2).
- res_id  out  IDW  index of the requester that supplied the word.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values (synchronous rst):
  - state=IDLE, rr_ptr=0, residue=R0 (one-hot 3'b001), shift register=0, bit count=0.
  - req_ready=0, res_valid=0, res_div3=0, res_rem=0, res_id=0, busy=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - Round-robin search over req_valid, starting at rr_ptr and wrapping modulo NREQ.
  - If a requester g is found: req_ready[g]=1 combinationally in the same cycle, with at most one ready bit set. At the accepting edge: capture req_data[g], latch res_id=g, set residue=R0, count=0, rr_ptr=(g+1) mod NREQ, and go to SHIFT.
  - If no req_valid is set: req_ready=0 and stay in IDLE.
  - A requester may drop req_valid before it is granted; nothing is committed.
- SHIFT:
  - One bit per edge, MSB first: r' = (2r + bit) mod 3.
  - One-hot residue transitions: R0: bit=1→R1, bit=0→R0. R1: bit=1→R0, bit=0→R2. R2: bit=1→R2, bit=0→R1.
  - After DW shift edges, go to DONE. req_ready is all zero throughout SHIFT.
- DONE:
  - res_valid=1; res_div3=(residue==R0); res_rem = 0, 1 or 2 for R0, R1, R2 respectively.
  - Outputs are held stable while res_valid & !res_ready.
  - On res_valid & res_ready: go to IDLE and drop res_valid at that edge.
  - No new word is accepted in DONE.
- Latency: res_valid rises exactly DW cycles after the accepting edge. Minimum throughput is one word per DW+2 cycles (accept in IDLE, DW shift edges, at least one DONE cycle with res_ready high, return to IDLE).
- Illegal residue or state encoding recovers to R0 / IDLE on the next edge.
- rst mid-SHIFT or mid-DONE: the word in progress is discarded, no result is produced, and rst overrides all other events.
- res_id is valid only while res_valid is high. Its value is otherwise undefined but is held.

Optional Feature:
- Macro: DIV3_STATS_EN.
- When defined:
  - Extra output port stat_div_cnt [15:0]: count of completed results with res_div3=1. Incremented on each res_valid & res_ready handshake where res_div3=1.
  - The counter saturates at 16'hFFFF and is cleared by rst.
- When undefined: the port and the counter are absent, and behaviour is otherwise identical.

Decomposition:
- Package div3_pkg:
  - FSM state encoding (IDLE, SHIFT, DONE).
  - One-hot residue constants R0=3'b001, R1=3'b010, R2=3'b100.
  - A function mapping residue to the 2-bit remainder.
- One sub-module, mod3_step: combinational next-residue from (residue, bit), with illegal input mapped to R0. It is instantiated once.
- Round-robin search and the FSM stay in the top level.

Test Plan:
- Single requester 0, DW=8, data 8'd0 → res_valid 8 cycles after accept; res_div3=1, res_rem=0, res_id=0.
- Data 8'd255 → div3=1, rem=0. 8'd7 → div3=0, rem=1. 8'd8 → div3=0, rem=2. 8'd200 → rem=2. Exhaustive 0..255 through requester 1 checked against a modulo model.
- All 4 requesters valid continuously, res_ready=1 → grant order 0,1,2,3,0; each result carries the matching res_id and correct remainder.
- res_ready held low for 5 cycles in DONE → res_valid and result outputs stable, req_ready all 0; completes on the first res_ready=1 edge.
- rst asserted for 1 cycle at the 4th SHIFT bit → no res_valid, rr_ptr=0. The next word 8'd9 from requester 2 then gives div3=1, res_id=2.
- With DIV3_STATS_EN defined: 10 results with 6 divisible → stat_div_cnt=6. Force the counter to 16'hFFFF, then one more divisible result → counter stays at 16'hFFFF.

Source files
------------

// File: rtl/div3_pkg.sv
// Shared definitions for div3_serial_sched: FSM states, one-hot residue
// encodings and the residue-to-remainder mapping.
package div3_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // One-hot residue of the partial word modulo 3.
  localparam logic [2:0] R0 = 3'b001;
  localparam logic [2:0] R1 = 3'b010;
  localparam logic [2:0] R2 = 3'b100;

  // Maps a one-hot residue to its 2-bit remainder; anything illegal reads as 0.
  function automatic logic [1:0] residue_to_rem(input logic [2:0] r);
    case (r)
      R1:      return 2'd1;
      R2:      return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  // True only for the three legal one-hot residue codes.
  function automatic logic residue_legal(input logic [2:0] r);
    return (r == R0) || (r == R1) || (r == R2);
  endfunction

endpackage

// File: rtl/div3_serial_sched_if.sv
// Request/result bundle for div3_serial_sched. The master side belongs to
// the producers and the result consumer; the slave side is the scheduler.
interface div3_serial_sched_if #(
  parameter int NREQ = 4,
  parameter int DW   = 8
);
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               res_valid;
  logic               res_ready;
  logic               res_div3;
  logic [1:0]         res_rem;
  logic [IDW-1:0]     res_id;
  logic               busy;

  modport master (
    output req_valid, req_data, res_ready,
    input  req_ready, res_valid, res_div3, res_rem, res_id, busy
  );

  modport slave (
    input  req_valid, req_data, res_ready,
    output req_ready, res_valid, res_div3, res_rem, res_id, busy
  );
endinterface

// File: rtl/mod3_step.sv
// One MSB-first step of the mod-3 residue engine: r' = (2r + din) mod 3,
// on one-hot residues. Any illegal residue input recovers to R0.
module mod3_step
  import div3_pkg::*;
(
  input  logic [2:0] residue,
  input  logic       din,
  output logic [2:0] residue_next
);

  // Next-residue table.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so
    // no path through the case can leave it unassigned and infer a latch.
    residue_next = R0;
    case (residue)
      R0:      residue_next = din ? R1 : R0;
      R1:      residue_next = din ? R0 : R2;
      R2:      residue_next = din ? R2 : R1;
      default: residue_next = R0;
    endcase
  end

endmodule

// File: rtl/div3_serial_sched.sv
// Round-robin scheduler sharing one serial mod-3 residue engine among NREQ
// requesters. A granted word is shifted MSB-first through mod3_step, one bit
// per clock, and the result is offered on a valid/ready port.
// Optional build macro DIV3_STATS_EN adds the stat_div_cnt output, a
// saturating count of completed results that were divisible by 3.
module div3_serial_sched
  import div3_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int DW   = 8
) (
  input  logic clk,
  input  logic rst,
  div3_serial_sched_if.slave bus
`ifdef DIV3_STATS_EN
  ,
  output logic [15:0] stat_div_cnt
`endif
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW  = $clog2(DW);

  state_t          state, state_next;
  logic [IDW-1:0]  rr_ptr;
  logic [2:0]      residue;
  logic [2:0]      residue_step;
  logic [DW-1:0]   shreg;
  logic [CW-1:0]   cnt;
  logic [IDW-1:0]  res_id_q;

  logic            found;
  logic [IDW-1:0]  grant;
  logic [NREQ-1:0] req_ready_c;
  logic            res_hs;

  // Position k of the round-robin search that starts at base.
  function automatic logic [IDW-1:0] rr_index(input logic [IDW-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NREQ) s = s - NREQ;
    return IDW'(s);
  endfunction

  // Round-robin search: first valid requester at or after rr_ptr.
  always_comb begin
    found = 1'b0;
    grant = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!found && bus.req_valid[rr_index(rr_ptr, k)]) begin
        found = 1'b1;
        grant = rr_index(rr_ptr, k);
      end
    end
  end

  mod3_step u_step (
    .residue      (residue),
    .din          (shreg[DW-1]),
    .residue_next (residue_step)
  );

  // FSM next state and the one-hot grant.
  always_comb begin
    state_next  = state;
    req_ready_c = '0;
    case (state)
      ST_IDLE: begin
        if (found) begin
          req_ready_c[grant] = 1'b1;
          state_next         = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (cnt == CW'(DW - 1)) state_next = ST_DONE;
      end
      ST_DONE: begin
        if (bus.res_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    // NOTE: sequential state is written with non-blocking assignments so all
    // registers update from pre-edge values regardless of statement order.
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // Datapath: capture on accept, shift during SHIFT, hold otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      residue  <= R0;
      shreg    <= '0;
      cnt      <= '0;
      res_id_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (found) begin
            shreg    <= bus.req_data[int'(grant)*DW +: DW];
            res_id_q <= grant;
            residue  <= R0;
            cnt      <= '0;
            rr_ptr   <= (grant == IDW'(NREQ - 1)) ? '0 : grant + 1'b1;
          end else if (!residue_legal(residue)) begin
            residue <= R0;
          end
        end
        ST_SHIFT: begin
          shreg   <= {shreg[DW-2:0], 1'b0};
          residue <= residue_step;
          cnt     <= cnt + 1'b1;
        end
        default: begin
          if (!residue_legal(residue)) residue <= R0;
        end
      endcase
    end
  end

  assign res_hs        = (state == ST_DONE) && bus.res_ready;
  assign bus.req_ready = req_ready_c;
  assign bus.res_valid = (state == ST_DONE);
  assign bus.res_div3  = (state == ST_DONE) && (residue == R0);
  assign bus.res_rem   = (state == ST_DONE) ? residue_to_rem(residue) : 2'd0;
  assign bus.res_id    = res_id_q;
  assign bus.busy      = (state != ST_IDLE);

`ifdef DIV3_STATS_EN
  // Saturating count of divisible results handed to the consumer.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_div_cnt <= '0;
    end else if (res_hs && (residue == R0) && (stat_div_cnt != 16'hFFFF)) begin
      stat_div_cnt <= stat_div_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_div3_serial_sched.sv
// Self-checking bench for div3_serial_sched: directed steps with a
// scoreboard of expected results pushed on accept and popped on result.
module tb_div3_serial_sched;

  localparam int NREQ = 4;
  localparam int DW   = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  div3_serial_sched_if #(.NREQ(NREQ), .DW(DW)) bus ();

`ifdef DIV3_STATS_EN
  logic [15:0] stat_div_cnt;
`endif

  div3_serial_sched #(.NREQ(NREQ), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef DIV3_STATS_EN
    ,
    .stat_div_cnt (stat_div_cnt)
`endif
  );

  typedef struct {
    int id;
    int rem;
  } exp_t;

  exp_t sb[$];
  int   grant_log[$];
  int   checks     = 0;
  int   errors     = 0;
  int   accept_cnt = 0;
  int   result_cnt = 0;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Let combinational outputs settle, record handshakes due at the next
  // edge, then advance to the following falling edge.
  task automatic step();
    int   gid;
    int   data;
    exp_t e;
    #1;
    if (!rst) begin
      if (|(bus.req_valid & bus.req_ready)) begin
        check("ready_onehot", $countones(bus.req_ready), 1);
        gid = 0;
        for (int i = 0; i < NREQ; i++)
          if (bus.req_valid[i] && bus.req_ready[i]) gid = i;
        data  = int'(bus.req_data[gid*DW +: DW]);
        e.id  = gid;
        e.rem = data % 3;
        sb.push_back(e);
        grant_log.push_back(gid);
        accept_cnt++;
      end
      if (bus.res_valid && bus.res_ready) begin
        result_cnt++;
        if (sb.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          e = sb.pop_front();
          check("res_id", int'(bus.res_id), e.id);
          check("res_rem", int'(bus.res_rem), e.rem);
          check("res_div3", int'(bus.res_div3), (e.rem == 0) ? 1 : 0);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) step();
    rst = 1'b0;
    sb.delete();
    grant_log.delete();
  endtask

  task automatic wait_accept();
    int start;
    int g;
    start = accept_cnt;
    g     = 0;
    while (accept_cnt == start && g < 50) begin
      step();
      g++;
    end
    check("accept_timeout", (accept_cnt != start) ? 1 : 0, 1);
  endtask

  task automatic wait_res_valid(output int lat);
    lat = 0;
    while (!bus.res_valid && lat < 100) begin
      step();
      lat++;
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((sb.size() != 0 || bus.busy) && g < 200) begin
      step();
      g++;
    end
    check("drain_timeout", (g < 200) ? 1 : 0, 1);
  endtask

  // One word from one requester with the consumer always ready.
  task automatic run_word(input int id, input int data);
    int lat;
    int start;
    bus.req_valid             = '0;
    bus.req_valid[id]         = 1'b1;
    bus.req_data[id*DW +: DW] = DW'(data);
    bus.res_ready             = 1'b1;
    wait_accept();
    bus.req_valid[id] = 1'b0;
    wait_res_valid(lat);
    check("latency", lat, DW);
    start = result_cnt;
    step();
    check("result_taken", result_cnt - start, 1);
    check("idle_after", int'(bus.busy), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int seen;
    int start;

    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.res_ready = 1'b0;
    @(negedge clk);

    // Reset state.
    do_reset(2);
    check("rst_req_ready", int'(bus.req_ready), 0);
    check("rst_res_valid", int'(bus.res_valid), 0);
    check("rst_res_div3", int'(bus.res_div3), 0);
    check("rst_res_rem", int'(bus.res_rem), 0);
    check("rst_res_id", int'(bus.res_id), 0);
    check("rst_busy", int'(bus.busy), 0);
    step();
    check("idle_no_req_ready", int'(bus.req_ready), 0);
    check("idle_no_busy", int'(bus.busy), 0);

    // Directed words through requester 0.
    run_word(0, 0);
    run_word(0, 255);
    run_word(0, 7);
    run_word(0, 8);
    run_word(0, 200);

    // Exhaustive sweep through requester 1.
    for (int v = 0; v < 256; v++) run_word(1, v);

    // All requesters valid continuously: grant order from rr_ptr = 0.
    do_reset(1);
    bus.req_data  = {8'd24, 8'd23, 8'd22, 8'd21};
    bus.req_valid = '1;
    bus.res_ready = 1'b1;
    start = 0;
    while (accept_cnt < start + 0) step();
    start = accept_cnt;
    seen  = 0;
    while (accept_cnt < start + 5 && seen < 200) begin
      step();
      seen++;
    end
    bus.req_valid = '0;
    drain();
    check("rr_count", grant_log.size(), 5);
    if (grant_log.size() == 5) begin
      check("rr_grant0", grant_log[0], 0);
      check("rr_grant1", grant_log[1], 1);
      check("rr_grant2", grant_log[2], 2);
      check("rr_grant3", grant_log[3], 3);
      check("rr_grant4", grant_log[4], 0);
    end

    // Result back-pressure: outputs held, nothing accepted while in DONE.
    bus.res_ready            = 1'b0;
    bus.req_data[0*DW +: DW] = 8'd8;
    bus.req_valid[0]         = 1'b1;
    wait_accept();
    bus.req_valid[0] = 1'b0;
    wait_res_valid(lat);
    check("bp_latency", lat, DW);
    bus.req_data[3*DW +: DW] = 8'd5;
    bus.req_valid[3]         = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_res_valid", int'(bus.res_valid), 1);
      check("bp_res_div3", int'(bus.res_div3), 0);
      check("bp_res_rem", int'(bus.res_rem), 2);
      check("bp_res_id", int'(bus.res_id), 0);
      check("bp_req_ready", int'(bus.req_ready), 0);
    end
    bus.req_valid[3] = 1'b0;
    bus.res_ready    = 1'b1;
    start = result_cnt;
    step();
    check("bp_released", result_cnt - start, 1);
    check("bp_res_valid_drop", int'(bus.res_valid), 0);
    check("bp_busy_drop", int'(bus.busy), 0);

    // Reset in the 4th shift cycle discards the word in flight.
    bus.req_data[1*DW +: DW] = 8'd100;
    bus.req_valid[1]         = 1'b1;
    wait_accept();
    bus.req_valid[1] = 1'b0;
    repeat (3) step();
    check("mid_busy_before_rst", int'(bus.busy), 1);
    do_reset(1);
    check("mid_rst_busy", int'(bus.busy), 0);
    check("mid_rst_res_valid", int'(bus.res_valid), 0);
    seen = 0;
    for (int i = 0; i < DW + 2; i++) begin
      step();
      if (bus.res_valid) seen++;
    end
    check("mid_rst_no_result", seen, 0);

    // After reset rr_ptr is 0: requester 0 wins over 2, then 2 (word 9).
    bus.req_data[0*DW +: DW] = 8'd3;
    bus.req_data[2*DW +: DW] = 8'd9;
    bus.req_valid            = 4'b0101;
    start = accept_cnt;
    seen  = 0;
    while (accept_cnt < start + 2 && seen < 200) begin
      step();
      if (accept_cnt == start + 1) bus.req_valid[0] = 1'b0;
      seen++;
    end
    bus.req_valid = '0;
    drain();
    check("post_rst_count", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      check("post_rst_grant0", grant_log[0], 0);
      check("post_rst_grant1", grant_log[1], 2);
    end

`ifdef DIV3_STATS_EN
    // Saturating divisible-result counter.
    do_reset(1);
    check("stat_rst", int'(stat_div_cnt), 0);
    run_word(0, 0);
    run_word(1, 1);
    run_word(2, 3);
    run_word(3, 2);
    run_word(0, 6);
    run_word(1, 9);
    run_word(2, 4);
    run_word(3, 12);
    run_word(0, 5);
    run_word(1, 15);
    check("stat_six", int'(stat_div_cnt), 6);
    force dut.stat_div_cnt = 16'hFFFF;
    step();
    release dut.stat_div_cnt;
    run_word(2, 3);
    check("stat_saturate", int'(stat_div_cnt), 65535);
`endif

    check("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
